instruction_fetch_queue: RTL and testbench

- Fetch stage of the RV64 core; sits directly upstream of the decode stage and its immediate extraction.
- Holds the 64-bit fetch PC and issues 32-bit instruction reads to instruction memory, with at most one read outstanding.
- Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects: the queue is flushed and any in-flight response is discarded.

---
 rtl/instruction_fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: RV64 fetch stage. It holds the fetch PC, keeps at most one 32-bit
//   imem read outstanding, and buffers the returned words with their PCs for decode.
// Latency: with gnt=1 and a 1-cycle memory, a request accepted in cycle N is seen on out_* in N+2.
// Backpressure: fetch stalls (imem_req=0) once queued + in-flight entries reach DEPTH.
//   A pop in the same cycle does not free a slot for that cycle's request.
// Ports: clk/reset (sync, active-high); imem_req/addr/gnt/rvalid/rdata memory side;
//   redirect_valid/redirect_pc flush and refetch; out_valid/ready/pc/instruction to decode.
// Optional: define INSTRUCTION_FETCH_QUEUE_PERF_EN to add the perf_fetched/perf_dropped counters.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instruction
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [63:0]   pc;
  logic [63:0]   req_pc;      // PC of the read currently outstanding
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [63:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];

  logic        in_wait;
  logic [CW:0] occupancy;
  logic        credit;
  logic        issue;
  logic        push;
  logic        pop;
  logic [1:0]  unused_rpc_lsb;

  assign unused_rpc_lsb = redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The outstanding read already owns a slot, so it is counted against DEPTH.
  // This keeps a push from ever landing on a full queue.
  assign in_wait   = (state == S_WAIT);
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, in_wait};
  assign credit    = (occupancy < DEPTH_C);

  // In S_WAIT the next read may go out in the same cycle the current one returns.
  // This gives one fetch per cycle with a 1-cycle memory.
  assign imem_req  = !reset && !redirect_valid && credit &&
                     ((state == S_IDLE) || (in_wait && imem_rvalid));
  assign imem_addr = pc;
  assign issue     = imem_req && imem_gnt;

  // A response that arrives in the redirect cycle belongs to the old stream.
  assign push = in_wait && imem_rvalid && !redirect_valid;

  assign out_valid       = !reset && (count != '0);
  assign pop             = out_valid && out_ready && !redirect_valid;
  assign out_pc          = out_valid ? fifo_pc[head]  : 64'h0;
  assign out_instruction = out_valid ? fifo_ins[head] : 32'h0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   state_nxt = imem_rvalid ? S_IDLE : S_DROP;
        else if (imem_rvalid) state_nxt = issue ? S_WAIT : S_IDLE;
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= 64'h0;
      state  <= S_IDLE;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc    <= {redirect_pc[63:2], 2'b00};
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (issue) begin
          pc     <= pc + 64'd4;
          req_pc <= pc;
        end
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // The storage has no reset. Only entries below count are ever read out.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_pc[tail]  <= req_pc;
      fifo_ins[tail] <= imem_rdata;
    end
  end

`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic drop_resp;
  assign drop_resp = (state == S_DROP) && imem_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(drop_resp) +
                      (redirect_valid ? 32'(count) : 32'd0);
    end
  end
`endif

  // Memory must only answer a read that was granted.
  a_no_rvalid_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (state == S_IDLE)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction)
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Memory model: one read in flight, answered mem_cnt cycles after the first possible cycle.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = 64'h0;

  // Reference model of the fetch queue.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        m_q[$];
  logic [63:0] m_pc   = 64'h0;
  logic [63:0] m_opc  = 64'h0;
  bit          m_out  = 1'b0;
  bit          m_keep = 1'b0;

  // DUT outputs sampled in the current cycle.
  logic        s_req;
  logic [63:0] s_addr;
  logic        s_vld;
  logic [63:0] s_pc;
  logic [31:0] s_ins;

  typedef struct {
    bit          rst, g, rdy, rd;
    logic [63:0] rpc;
    int          md;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_vld;
    logic [63:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] rdata_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A00_0013;
  endfunction

  function automatic vec_t v(input bit rst, input bit g, input bit rdy, input bit rd,
                             input logic [63:0] rpc, input int md, input bit er,
                             input logic [63:0] ea, input bit ev, input logic [63:0] ep);
    vec_t t;
    t.rst = rst; t.g = g; t.rdy = rdy; t.rd = rd; t.rpc = rpc; t.md = md;
    t.e_req = er; t.e_addr = ea; t.e_vld = ev; t.e_pc = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample and compare, then advance both models.
  task automatic step(input bit rst, input bit g, input bit rdy, input bit rd,
                      input logic [63:0] rpc, input int md, input bit use_model);
    bit          rv;
    bit          e_req;
    bit          e_vld;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    ent_t        ent;
    @(negedge clk);
    rv             = mem_busy && (mem_cnt == 0);
    reset          = rst;
    imem_gnt       = g;
    out_ready      = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = rv;
    imem_rdata     = rv ? rdata_of(mem_addr) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_vld = out_valid;
    s_pc  = out_pc;   s_ins  = out_instruction;

    e_vld = !rst && (m_q.size() != 0);
    e_pc  = e_vld ? m_q[0].pc  : 64'h0;
    e_ins = e_vld ? m_q[0].ins : 32'h0;
    e_req = !rst && !rd && ((m_q.size() + ((m_out && m_keep) ? 1 : 0)) < DEPTH) &&
            (!m_out || (m_keep && rv));
    if (use_model) begin
      chk("mdl_req",   64'(s_req), 64'(e_req));
      chk("mdl_addr",  s_addr,     m_pc);
      chk("mdl_valid", 64'(s_vld), 64'(e_vld));
      chk("mdl_pc",    s_pc,       e_pc);
      chk("mdl_ins",   64'(s_ins), 64'(e_ins));
    end

    if (rst) begin
      m_q.delete();
      m_pc = RESET_PC; m_out = 1'b0; m_keep = 1'b0;
    end else if (rd) begin
      if (m_out && rv) m_out = 1'b0;
      else if (m_out)  m_keep = 1'b0;
      m_q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (e_vld && rdy) void'(m_q.pop_front());
      if (m_out && rv) begin
        if (m_keep) begin
          ent.pc = m_opc; ent.ins = imem_rdata;
          m_q.push_back(ent);
        end
        m_out = 1'b0;
      end
      if (e_req && g) begin
        m_out = 1'b1; m_keep = 1'b1; m_opc = m_pc; m_pc = m_pc + 64'd4;
      end
    end

    if (rv) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (s_req && g) begin
      mem_busy = 1'b1; mem_addr = s_addr; mem_cnt = md;
    end
    if (rst) mem_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;

    // Fields: rst gnt rdy redir rpc mdelay | req addr valid pc
    tbl.push_back(v(1,0,0,0,64'h0,0,  0,64'h0,  0,64'h0));   // reset state
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h0,  0,64'h0));   // first request at RESET_PC
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h4,  0,64'h0));   // back-to-back issue
    tbl.push_back(v(0,1,1,0,64'h0,0,  0,64'h8,  1,64'h0));   // first out in cycle 2; no credit
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h8,  1,64'h4));
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'hc,  0,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  0,64'h10, 1,64'h8));
    tbl.push_back(v(0,1,0,0,64'h0,0,  1,64'h10, 1,64'hc));   // decode stalls
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h14, 1,64'hc));
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h14, 1,64'hc));   // full: two entries held
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h14, 1,64'hc));
    tbl.push_back(v(1,1,0,0,64'h0,0,  0,64'h14, 0,64'h0));   // mid-stream reset
    tbl.push_back(v(0,1,0,0,64'h0,0,  1,64'h0,  0,64'h0));   // back at RESET_PC, queue empty
    tbl.push_back(v(0,1,0,0,64'h0,0,  1,64'h4,  0,64'h0));
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h8,  1,64'h0));
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h8,  1,64'h0));   // pc 0,4 buffered, head stable
    tbl.push_back(v(0,1,0,0,64'h0,0,  0,64'h8,  1,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  0,64'h8,  1,64'h0));   // pop; same-cycle pop not credited
    tbl.push_back(v(0,1,0,0,64'h0,1,  1,64'h8,  1,64'h4));   // resume at 8, slow response
    tbl.push_back(v(0,1,1,1,64'h100,0,0,64'hc,  1,64'h4));   // redirect, read for 8 in flight
    tbl.push_back(v(0,1,1,0,64'h0,0,  0,64'h100,0,64'h0));   // response for 8 dropped
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h100,0,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h104,0,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  0,64'h108,1,64'h100)); // first out after redirect
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h108,1,64'h104));
    tbl.push_back(v(0,1,1,1,64'h203,0,0,64'h10c,0,64'h0));   // redirect with rvalid
    tbl.push_back(v(0,0,1,0,64'h0,0,  1,64'h200,0,64'h0));   // aligned, idle again
    tbl.push_back(v(0,0,1,1,64'h40,0, 0,64'h200,0,64'h0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(0,0,1,0,64'h0,0,1,64'h40, 0,64'h0));   // no grant: request held
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h40, 0,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h44, 0,64'h0));   // granted: pc advanced
    tbl.push_back(v(0,1,1,1,64'hffff_ffff_ffff_fffe,0,0,64'h48,1,64'h40));
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'hffff_ffff_ffff_fffc,0,64'h0));
    tbl.push_back(v(0,1,1,0,64'h0,0,  1,64'h0,  0,64'h0));   // pc wraps to 0

    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].g, tbl[i].rdy, tbl[i].rd, tbl[i].rpc, tbl[i].md, 1'b1);
      chk($sformatf("vec%0d_req", i),   64'(s_req), 64'(tbl[i].e_req));
      chk($sformatf("vec%0d_addr", i),  s_addr,     tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 64'(s_vld), 64'(tbl[i].e_vld));
      chk($sformatf("vec%0d_pc", i),    s_pc,       tbl[i].e_pc);
      chk($sformatf("vec%0d_ins", i),   64'(s_ins),
          tbl[i].e_vld ? 64'(rdata_of(tbl[i].e_pc)) : 64'h0);
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
      if (i == 12) begin
        chk("perf_fetched_after_reset", 64'(perf_fetched), 64'h0);
        chk("perf_dropped_after_reset", 64'(perf_dropped), 64'h0);
      end
`endif
    end

    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0,
           {$urandom, $urandom},
           int'($urandom_range(0, 2)),
           1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
